// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the convolutional encoder: frames the upstream bit stream,
// clears the encoder, then issues FRAME_LEN data bits and CONSTRAINT_LEN-1 zero tail bits.
// Optional: define CONV_FRAME_AUTORESTART_EN to run frames back-to-back after one start.
module conv_frame_ctrl #(
    parameter int unsigned FRAME_LEN      = 64,
    parameter int unsigned CONSTRAINT_LEN = 3,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk20M_sig,
    input  logic             reset_sig,
    input  logic             start_sig,
    input  logic             in_bit_sig,
    input  logic             in_valid_sig,
    output logic             in_ready_sig,
    output logic             enc_clr_sig,
    output logic             enc_en_sig,
    output logic             enc_bit_sig,
    output logic             sof_sig,
    output logic             eof_sig,
    output logic             busy_sig,
    output logic [CNT_W-1:0] frame_cnt_sig
);

    localparam int unsigned TAIL_LEN = CONSTRAINT_LEN - 1;
    localparam int unsigned BIT_W    = $clog2(FRAME_LEN + 1);
    localparam int unsigned TAIL_W   = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(FRAME_LEN - 1);
    localparam logic [TAIL_W-1:0] LAST_TAIL = TAIL_W'(TAIL_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DATA,
        TAIL
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [BIT_W-1:0]   bit_cnt;
    logic [TAIL_W-1:0]  tail_cnt;
    logic [CNT_W-1:0]   frame_cnt;
    logic               enc_en_q;
    logic               enc_bit_q;
    logic               sof_q;
    logic               eof_q;

    logic               accept;
    logic               tail_issue;
    logic               last_tail;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        tail_issue = 1'b0;
        last_tail  = 1'b0;
        case (state)
            IDLE: begin
                if (start_sig) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                next_state = DATA;
            end
            DATA: begin
                // in_ready_sig is 1 throughout DATA, so valid alone is an accept
                if (in_valid_sig) begin
                    accept = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        next_state = TAIL;
                    end
                end
            end
            TAIL: begin
                tail_issue = 1'b1;
                if (tail_cnt == LAST_TAIL) begin
                    last_tail = 1'b1;
`ifdef CONV_FRAME_AUTORESTART_EN
                    next_state = CLEAR;
`else
                    next_state = IDLE;
`endif
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk20M_sig) begin
        if (reset_sig) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tail_cnt  <= '0;
            frame_cnt <= '0;
            enc_en_q  <= 1'b0;
            enc_bit_q <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            state     <= next_state;
            enc_en_q  <= accept | tail_issue;
            enc_bit_q <= accept & in_bit_sig;
            sof_q     <= accept & (bit_cnt == '0);
            eof_q     <= last_tail;

            if (state == CLEAR) begin
                bit_cnt <= '0;
            end else if (accept) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (state != TAIL) begin
                tail_cnt <= '0;
            end else begin
                tail_cnt <= tail_cnt + TAIL_W'(1);
            end

            if (last_tail) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready_sig  = (state == DATA);
    assign enc_clr_sig   = (state == CLEAR);
    assign enc_en_sig    = enc_en_q;
    assign enc_bit_sig   = enc_bit_q;
    assign sof_sig       = sof_q;
    assign eof_sig       = eof_q;
    assign busy_sig      = (state != IDLE) | enc_en_q;
    assign frame_cnt_sig = frame_cnt;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl: frame-level reference model compared every cycle,
// plus literal expectations for frame length, pulse spacing, reset abort and counter wrap.
module tb_conv_frame_ctrl;

    localparam int FL = 64;
    localparam int K  = 3;
    localparam int TL = K - 1;

    logic clk = 1'b0;
    always #25 clk = ~clk;

    logic        rst, start, in_bit, in_valid, start2;
    logic        in_ready, enc_clr, enc_en, enc_bit, sof, eof, busy;
    logic [15:0] frame_cnt;
    logic        in_ready2, enc_clr2, enc_en2, enc_bit2, sof2, eof2, busy2;
    logic [1:0]  frame_cnt2;

    conv_frame_ctrl #(.FRAME_LEN(FL), .CONSTRAINT_LEN(K), .CNT_W(16)) dut (
        .clk20M_sig(clk), .reset_sig(rst), .start_sig(start), .in_bit_sig(in_bit),
        .in_valid_sig(in_valid), .in_ready_sig(in_ready), .enc_clr_sig(enc_clr),
        .enc_en_sig(enc_en), .enc_bit_sig(enc_bit), .sof_sig(sof), .eof_sig(eof),
        .busy_sig(busy), .frame_cnt_sig(frame_cnt)
    );

    conv_frame_ctrl #(.FRAME_LEN(4), .CONSTRAINT_LEN(3), .CNT_W(2)) dut2 (
        .clk20M_sig(clk), .reset_sig(rst), .start_sig(start2), .in_bit_sig(1'b1),
        .in_valid_sig(1'b1), .in_ready_sig(in_ready2), .enc_clr_sig(enc_clr2),
        .enc_en_sig(enc_en2), .enc_bit_sig(enc_bit2), .sof_sig(sof2), .eof_sig(eof2),
        .busy_sig(busy2), .frame_cnt_sig(frame_cnt2)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: a frame is "cleared" once, then owes FL accepted bits, then TL zeros.
    int          cyc = 0;
    bit          m_active = 0, m_cleared = 0;
    int          m_got = 0, m_tail = 0;
    logic [15:0] m_frames = '0;
    logic        e_en = 0, e_bit = 0, e_sof = 0, e_eof = 0;

    always @(posedge clk) begin
        cyc++;
        e_en = 0; e_bit = 0; e_sof = 0; e_eof = 0;
        if (rst) begin
            m_active = 0; m_cleared = 0; m_got = 0; m_tail = 0; m_frames = '0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_cleared = 0;
            end
        end else if (!m_cleared) begin
            m_cleared = 1; m_got = 0; m_tail = 0;
        end else if (m_got < FL) begin
            if (in_valid) begin
                e_en = 1; e_bit = in_bit; e_sof = (m_got == 0); m_got++;
            end
        end else begin
            e_en = 1; m_tail++;
            if (m_tail == TL) begin
                e_eof = 1; m_frames++; m_got = 0; m_tail = 0;
`ifdef CONV_FRAME_AUTORESTART_EN
                m_cleared = 0;
`else
                m_active = 0;
`endif
            end
        end
    end

    bit       chk_en = 0;
    int       clr_n = 0, en_n = 0, eof_n = 0, sof_cyc = 0, eof_cyc = 0;
    logic [1:0] last2 = '0;
    int       en2_n = 0, eof2_n = 0, clr2_cyc = 0, sof2_cyc = 0, eof2_cyc = 0;

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("ready", in_ready, m_active && m_cleared && (m_got < FL));
            check("clr",   enc_clr,  m_active && !m_cleared);
            check("en",    enc_en,   e_en);
            check("bit",   enc_bit,  e_bit);
            check("sof",   sof,      e_sof);
            check("eof",   eof,      e_eof);
            check("busy",  busy,     m_active || e_en);
            check("cnt",   frame_cnt, m_frames);
        end
        // statistics record the spec-style cycle number (period following edge cyc)
        if (enc_clr) clr_n++;
        if (enc_en) begin en_n++; last2 = {last2[0], enc_bit}; end
        if (sof) sof_cyc = cyc + 1;
        if (eof) begin eof_cyc = cyc + 1; eof_n++; end
        if (enc_en2) en2_n++;
        if (enc_clr2) clr2_cyc = cyc + 1;
        if (sof2) sof2_cyc = cyc + 1;
        if (eof2) begin eof2_cyc = cyc + 1; eof2_n++; end
    end

    task automatic wait_eofs(input int n, input int budget, input string name);
        int target;
        int k;
        target = eof_n + n;
        k = 0;
        while (eof_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_timeout"}, eof_n >= target, 1);
    endtask

    task automatic clear_stats();
        clr_n = 0; en_n = 0; last2 = '0;
    endtask

    int exp5[5] = '{1, 2, 3, 0, 1};

    initial begin
        int target;
        int e0;
        int k;
        rst = 1; start = 0; in_bit = 0; in_valid = 0; start2 = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("rst_ready", in_ready, 0);
        check("rst_busy",  busy, 0);
        check("rst_en",    enc_en, 0);
        check("rst_cnt",   frame_cnt, 0);
        rst = 0;

        // 1: plain frame, valid held high
        clear_stats();
        in_valid = 1; in_bit = 1; start = 1;
        @(negedge clk); start = 0;
        wait_eofs(1, 200, "t1");
        @(negedge clk);
        check("t1_clr_pulses", clr_n, 1);
        check("t1_en_cycles",  en_n, FL + TL);
        check("t1_sof_to_eof", eof_cyc - sof_cyc, 65);
        check("t1_tail_bits",  last2, 0);
        check("t1_busy_fall",  busy, 0);
        check("t1_frame_cnt",  frame_cnt, 1);

        // 2: 50% valid duty with random data
        clear_stats();
        start = 1; in_valid = 0;
        target = eof_n + 1;
        for (k = 0; k < 400 && eof_n < target; k++) begin
            @(negedge clk);
            start = 0;
            in_valid = ~in_valid;
            in_bit = 1'($urandom_range(0, 1));
        end
        check("t2_timeout", eof_n >= target, 1);
        in_valid = 0;
        @(negedge clk);
        check("t2_en_cycles", en_n, FL + TL);
        check("t2_tail_bits", last2, 0);
        check("t2_frame_cnt", frame_cnt, 2);

        // 3: start held high across a frame gives exactly two frames here
        clear_stats();
        in_valid = 1; in_bit = 1; start = 1;
        wait_eofs(2, 400, "t3");
        start = 0;
        @(negedge clk);
        check("t3_clr_pulses", clr_n, 2);
        check("t3_en_cycles",  en_n, 2 * (FL + TL));
        check("t3_busy_fall",  busy, 0);
        check("t3_frame_cnt",  frame_cnt, 4);

        // 4: reset after the 30th accepted bit aborts the frame
        clear_stats();
        target = eof_n;
        start = 1;
        @(negedge clk); start = 0;
        k = 0;
        while (m_got < 30 && k < 100) begin @(negedge clk); k++; end
        check("t4_reach_bit30", m_got, 30);
        rst = 1;
        @(negedge clk);
        check("t4_ready", in_ready, 0);
        check("t4_en",    enc_en, 0);
        check("t4_clr",   enc_clr, 0);
        check("t4_busy",  busy, 0);
        check("t4_cnt",   frame_cnt, 0);
        rst = 0;
        repeat (3) @(negedge clk);
        check("t4_no_eof", eof_n, target);
        clear_stats();
        start = 1;
        @(negedge clk); start = 0;
        wait_eofs(1, 200, "t4b");
        @(negedge clk);
        check("t4_en_cycles", en_n, FL + TL);
        check("t4_frame_cnt", frame_cnt, 1);

        // 5: FRAME_LEN=4, CNT_W=2 instance, five frames and counter wrap
        for (int f = 0; f < 5; f++) begin
            start2 = 1;
            e0 = cyc + 1;
            @(negedge clk); start2 = 0;
            k = 0;
            while (eof2_n <= f && k < 50) begin @(negedge clk); k++; end
            check("t5_timeout", eof2_n > f, 1);
            @(negedge clk);
            check("t5_frame_cnt", frame_cnt2, exp5[f]);
            if (f == 0) begin
                check("t5_clr_cycle", clr2_cyc - e0, 1);
                check("t5_sof_cycle", sof2_cyc - e0, 3);
                check("t5_eof_cycle", eof2_cyc - e0, 8);
            end
        end
        check("t5_en_cycles", en2_n, 5 * 6);
        check("t5_busy_fall", busy2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
